// File: rtl/pico_io_pkg.sv
// Shared definitions for the KCPSM6 I/O responder: register-map offsets, interrupt FSM
// encoding and the read-default value.
package pico_io_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SERV = 2'd2
    } irq_state_t;

    localparam logic [7:0] RD_DEFAULT = 8'h00;

    function automatic logic [7:0] off_status(input int num_regs);
        return 8'(num_regs);
    endfunction

    function automatic logic [7:0] off_mask(input int num_regs);
        return 8'(num_regs + 1);
    endfunction

endpackage

// File: rtl/pico_irq_ctrl.sv
// Interrupt request/acknowledge handshake toward the KCPSM6 (IDLE/REQ/SERV).
// The interrupt output is a flop; it is high only while the FSM sits in REQ.
module pico_irq_ctrl
    import pico_io_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_irq_req,
    input  logic       i_interrupt_ack,
    input  logic       i_status_wr_pulse,
    output logic       o_interrupt,
    output irq_state_t o_state
);

    irq_state_t r_state;
    irq_state_t w_next;
    logic       r_interrupt;
    logic       w_interrupt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IRQ_IDLE;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_interrupt <= w_interrupt_d;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IRQ_IDLE: if (i_irq_req) w_next = IRQ_REQ;
            IRQ_REQ: begin
                if (i_interrupt_ack)  w_next = IRQ_SERV;
                else if (!i_irq_req)  w_next = IRQ_IDLE;
            end
            IRQ_SERV: begin
                if (!i_irq_req)             w_next = IRQ_IDLE;
                else if (i_status_wr_pulse) w_next = IRQ_REQ;
            end
            default: w_next = IRQ_IDLE;
        endcase
        // Raised one cycle after entering REQ, dropped on the edge that leaves REQ.
        w_interrupt_d = (r_state == IRQ_REQ) && (w_next == IRQ_REQ);
    end

    assign o_interrupt = r_interrupt;
    assign o_state     = r_state;

endmodule

// File: rtl/pico_io_responder.sv
// KCPSM6 peripheral-side responder: control registers, W1C event pending, mask, registered read.
// Optional macro PICO_IO_RD_CLR_EN: a STATUS read with read_strobe clears the returned bits.
module pico_io_responder
    import pico_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         NUM_REGS  = 4,
    parameter int         EVT_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic [7:0]            out_port,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [7:0]            in_port,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    input  logic [EVT_W-1:0]      evt_in,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic [1:0]            o_irq_state
);

    localparam logic [7:0] OFF_STATUS = off_status(NUM_REGS);
    localparam logic [7:0] OFF_MASK   = off_mask(NUM_REGS);
    localparam int         LAST_ADDR  = int'(BASE_ADDR) + NUM_REGS + 1;

    generate
        if (LAST_ADDR > 255) begin : g_bad_window
            $error("pico_io_responder: register window runs past port_id 8'hFF");
        end
        if (NUM_REGS < 1 || NUM_REGS > 8 || EVT_W < 1 || EVT_W > 8) begin : g_bad_size
            $error("pico_io_responder: NUM_REGS and EVT_W must be 1..8");
        end
    endgenerate

    logic [7:0]       r_ctrl [NUM_REGS];
    logic [EVT_W-1:0] r_pending;
    logic [EVT_W-1:0] r_mask;
    logic [7:0]       r_in_port;
    logic             r_stat_wr;

    logic             w_in_win;
    logic [7:0]       w_off;
    logic             w_wr;
    logic             w_wr_status;
    logic             w_wr_mask;
    logic [EVT_W-1:0] w_w1c;
    logic [EVT_W-1:0] w_rd_clr;
    logic             w_irq_req;
    logic [7:0]       w_rd_data;
    irq_state_t       w_irq_state;

    assign w_in_win    = (port_id >= BASE_ADDR) && ({1'b0, port_id} <= 9'(LAST_ADDR));
    assign w_off       = port_id - BASE_ADDR;
    assign w_wr        = write_strobe && w_in_win;
    assign w_wr_status = w_wr && (w_off == OFF_STATUS);
    assign w_wr_mask   = w_wr && (w_off == OFF_MASK);
    assign w_w1c       = w_wr_status ? out_port[EVT_W-1:0] : '0;

`ifdef PICO_IO_RD_CLR_EN
    // The bits cleared are the ones the CPU is sampling on in_port this cycle.
    assign w_rd_clr = (read_strobe && w_in_win && (w_off == OFF_STATUS)) ?
                      r_in_port[EVT_W-1:0] : '0;
`else
    logic w_unused_rd_strobe;
    assign w_unused_rd_strobe = read_strobe;
    assign w_rd_clr = '0;
`endif

    assign w_irq_req = |(r_pending & r_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) r_ctrl[k] <= 8'h00;
            r_pending <= '0;
            r_mask    <= '0;
            r_in_port <= RD_DEFAULT;
            r_stat_wr <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr && (w_off == 8'(k))) r_ctrl[k] <= out_port;
            end
            if (w_wr_mask) r_mask <= out_port[EVT_W-1:0];
            // New events are ORed in after the clear so a same-cycle set wins.
            r_pending <= (r_pending & ~(w_w1c | w_rd_clr)) | evt_in;
            r_in_port <= w_rd_data;
            r_stat_wr <= w_wr_status | w_wr_mask;
        end
    end

    always_comb begin
        w_rd_data = RD_DEFAULT;
        if (w_in_win) begin
            if (w_off == OFF_STATUS) begin
                w_rd_data = 8'(r_pending);
            end else if (w_off == OFF_MASK) begin
                w_rd_data = 8'(r_mask);
            end else begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (w_off == 8'(k)) w_rd_data = r_ctrl[k];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
            assign reg_q[8*g +: 8] = r_ctrl[g];
        end
    endgenerate

    pico_irq_ctrl u_irq_ctrl (
        .i_clk             (clk),
        .i_rst_n           (reset),
        .i_irq_req         (w_irq_req),
        .i_interrupt_ack   (interrupt_ack),
        .i_status_wr_pulse (r_stat_wr),
        .o_interrupt       (interrupt),
        .o_state           (w_irq_state)
    );

    assign in_port     = r_in_port;
    assign o_irq_state = w_irq_state;

endmodule

// File: tb/tb_pico_io_responder.sv
// Self-checking bench for pico_io_responder (BASE_ADDR=8'h10, NUM_REGS=4, EVT_W=4).
module tb_pico_io_responder;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SERV = 2'd2;

    logic        clk;
    logic        reset;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack;
    logic [3:0]  evt_in;
    logic [31:0] reg_q;
    logic [1:0]  irq_state;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [7:0]  pid;
        logic        wr;
        logic [7:0]  dout;
        logic [7:0]  exp_in;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vt[15];

    pico_io_responder #(
        .BASE_ADDR (8'h10),
        .NUM_REGS  (4),
        .EVT_W     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .evt_in        (evt_in),
        .reg_q         (reg_q),
        .o_irq_state   (irq_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] pid, input logic [7:0] data);
        port_id      = pid;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [7:0] pid, input logic [7:0] exp);
        port_id = pid;
        exp_q.push_back(exp);
        tick();
        tick();
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, in_port);
        end else begin
            check(name, {24'h0, in_port}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic pulse_evt(input logic [3:0] bits);
        evt_in = bits;
        tick();
        evt_in = 4'h0;
    endtask

    task automatic cpu_ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n;
        n = 0;
        while (!interrupt && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'h0, interrupt}, 32'h1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        port_id = 8'h00;
        out_port = 8'h00;
        write_strobe = 1'b0;
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;
        evt_in = 4'h0;

        //             pid    wr    dout   exp_in exp_reg
        vt[0]  = '{8'h11, 1'b0, 8'h00, 8'h00, 32'h00000000};
        vt[1]  = '{8'h12, 1'b1, 8'hA5, 8'h00, 32'h00A50000};
        vt[2]  = '{8'h12, 1'b0, 8'h00, 8'hA5, 32'h00A50000};
        vt[3]  = '{8'h16, 1'b1, 8'hFF, 8'h00, 32'h00A50000};
        vt[4]  = '{8'h0F, 1'b1, 8'h77, 8'h00, 32'h00A50000};
        vt[5]  = '{8'h10, 1'b1, 8'h3C, 8'h00, 32'h00A5003C};
        vt[6]  = '{8'h13, 1'b1, 8'hC3, 8'h00, 32'hC3A5003C};
        vt[7]  = '{8'h10, 1'b0, 8'h00, 8'h3C, 32'hC3A5003C};
        vt[8]  = '{8'h13, 1'b0, 8'h00, 8'hC3, 32'hC3A5003C};
        vt[9]  = '{8'h15, 1'b1, 8'hFF, 8'h00, 32'hC3A5003C};
        vt[10] = '{8'h15, 1'b0, 8'h00, 8'h0F, 32'hC3A5003C};
        vt[11] = '{8'h15, 1'b1, 8'h00, 8'h0F, 32'hC3A5003C};
        vt[12] = '{8'h15, 1'b0, 8'h00, 8'h00, 32'hC3A5003C};
        vt[13] = '{8'h14, 1'b0, 8'h00, 8'h00, 32'hC3A5003C};
        vt[14] = '{8'h11, 1'b0, 8'h00, 8'h00, 32'hC3A5003C};

        repeat (3) tick();
        reset = 1'b1;
        check("rst_in_port", {24'h0, in_port}, 32'h0);
        check("rst_reg_q", reg_q, 32'h0);
        check("rst_interrupt", {31'h0, interrupt}, 32'h0);
        check("rst_state", {30'h0, irq_state}, {30'h0, S_IDLE});

        // Register map: one edge per vector, in_port reflects the map before that edge
        for (int i = 0; i < 15; i++) begin
            port_id      = vt[i].pid;
            write_strobe = vt[i].wr;
            out_port     = vt[i].dout;
            exp_q.push_back(vt[i].exp_in);
            tick();
            write_strobe = 1'b0;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tbl_in_port[%0d]: scoreboard empty", i);
            end else begin
                check($sformatf("tbl_in_port[%0d]", i), {24'h0, in_port}, {24'h0, exp_q.pop_front()});
            end
            check($sformatf("tbl_reg_q[%0d]", i), reg_q, vt[i].exp_reg);
            check($sformatf("tbl_irq[%0d]", i), {31'h0, interrupt}, 32'h0);
        end

        // Single event, ack, W1C back to idle
        cpu_write(8'h15, 8'h01);
        pulse_evt(4'b0001);
        port_id = 8'h14;
        tick();
        check("t3_status", {24'h0, in_port}, 32'h01);
        wait_irq("t3_irq_rise", 3);
        cpu_ack();
        check("t3_irq_drop", {31'h0, interrupt}, 32'h0);
        check("t3_state_serv", {30'h0, irq_state}, {30'h0, S_SERV});
        tick();
        check("t3_irq_low_serv", {31'h0, interrupt}, 32'h0);
        cpu_write(8'h14, 8'h01);
        tick();
        check("t3_state_idle", {30'h0, irq_state}, {30'h0, S_IDLE});
        read_expect("t3_status_clr", 8'h14, 8'h00);

        // Two events: partial W1C in SERV re-raises, final W1C does not
        cpu_write(8'h15, 8'h03);
        pulse_evt(4'b0011);
        wait_irq("t4_irq_rise", 4);
        cpu_ack();
        check("t4_irq_drop", {31'h0, interrupt}, 32'h0);
        cpu_write(8'h14, 8'h01);
        wait_irq("t4_reassert", 3);
        cpu_ack();
        check("t4_irq_drop2", {31'h0, interrupt}, 32'h0);
        cpu_write(8'h14, 8'h02);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                seen = seen | interrupt;
            end
            check("t4_irq_stays_low", {31'h0, seen}, 32'h0);
        end
        check("t4_state_idle", {30'h0, irq_state}, {30'h0, S_IDLE});

        // Set wins over a same-cycle W1C; optional read-clear
        port_id      = 8'h14;
        out_port     = 8'h04;
        write_strobe = 1'b1;
        evt_in       = 4'b0100;
        tick();
        write_strobe = 1'b0;
        evt_in       = 4'h0;
        tick();
        check("t5_set_wins", {24'h0, in_port}, 32'h04);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
`ifdef PICO_IO_RD_CLR_EN
        check("t5_after_read", {24'h0, in_port}, 32'h00);
`else
        check("t5_after_read", {24'h0, in_port}, 32'h04);
`endif
        cpu_write(8'h14, 8'h04);
        read_expect("t5_cleared", 8'h14, 8'h00);

        // Mask cleared while requesting drops the request
        cpu_write(8'h15, 8'h01);
        pulse_evt(4'b0001);
        wait_irq("mask_irq_rise", 4);
        cpu_write(8'h15, 8'h00);
        tick();
        check("mask_irq_drop", {31'h0, interrupt}, 32'h0);
        check("mask_state_idle", {30'h0, irq_state}, {30'h0, S_IDLE});
        cpu_write(8'h14, 8'h01);

        // Asynchronous reset with interrupt high and a write in flight
        cpu_write(8'h15, 8'h01);
        pulse_evt(4'b0001);
        wait_irq("t6_irq_rise", 4);
        port_id      = 8'h11;
        out_port     = 8'hAA;
        write_strobe = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_reg_q", reg_q, 32'h0);
        check("t6_async_in_port", {24'h0, in_port}, 32'h0);
        check("t6_async_irq", {31'h0, interrupt}, 32'h0);
        check("t6_async_state", {30'h0, irq_state}, {30'h0, S_IDLE});
        tick();
        write_strobe = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("t6_write_dropped", reg_q, 32'h0);
        check("t6_state_idle", {30'h0, irq_state}, {30'h0, S_IDLE});
        read_expect("t6_mask_zero", 8'h15, 8'h00);
        read_expect("t6_status_zero", 8'h14, 8'h00);
        check("t6_irq_low", {31'h0, interrupt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
